// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg : default 800x480 raster constants and line geometry helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcd_timing_pkg;

   localparam int unsigned C_H_ACTIVE = 800;
   localparam int unsigned C_H_SYNC   = 48;
   localparam int unsigned C_H_BP     = 40;
   localparam int unsigned C_H_FP     = 40;
   localparam int unsigned C_V_ACTIVE = 480;
   localparam int unsigned C_V_SYNC   = 3;
   localparam int unsigned C_V_BP     = 29;
   localparam int unsigned C_V_FP     = 13;
   localparam int unsigned C_PREFETCH = 16;

   // Line geometry in CLKs: total, first active pixel, writer window start.
   typedef struct packed {
      logic [31:0] ht;
      logic [31:0] a0;
      logic [31:0] w0;
   } lcd_geom_t;

   function automatic lcd_geom_t calc_geom(input int unsigned h_active,
                                           input int unsigned h_sync,
                                           input int unsigned h_bp,
                                           input int unsigned h_fp,
                                           input int unsigned prefetch);
      lcd_geom_t g;
      g.ht = 32'(2 * (h_sync + h_bp + h_active + h_fp));
      g.a0 = 32'(2 * (h_sync + h_bp));
      g.w0 = g.a0 - 32'd2 - 32'(prefetch);
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen : hc/vc raster counters and registered window decodes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = C_H_ACTIVE,
   parameter int unsigned H_SYNC   = C_H_SYNC,
   parameter int unsigned H_BP     = C_H_BP,
   parameter int unsigned H_FP     = C_H_FP,
   parameter int unsigned V_ACTIVE = C_V_ACTIVE,
   parameter int unsigned V_SYNC   = C_V_SYNC,
   parameter int unsigned V_BP     = C_V_BP,
   parameter int unsigned V_FP     = C_V_FP,
   parameter int unsigned PREFETCH = C_PREFETCH
) (
   input  logic clk,
   input  logic rst_n,
   output logic hsync,
   output logic vsync,
   output logic lcd_hs,
   output logic lcd_vs,
   output logic lcd_pclk,
   output logic pop_due_next,
   output logic de_next
);

   localparam lcd_geom_t   C_GEOM = calc_geom(H_ACTIVE, H_SYNC, H_BP, H_FP, PREFETCH);
   localparam int unsigned C_VT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned C_HC_W = $clog2(C_GEOM.ht);
   localparam int unsigned C_VC_W = $clog2(C_VT);

   localparam logic [C_HC_W-1:0] C_HT_M1  = C_HC_W'(C_GEOM.ht - 1);
   localparam logic [C_HC_W-1:0] C_A0     = C_HC_W'(C_GEOM.a0);
   localparam logic [C_HC_W-1:0] C_DE_HI  = C_HC_W'(C_GEOM.a0 + 2 * H_ACTIVE - 1);
   localparam logic [C_HC_W-1:0] C_POP_LO = C_HC_W'(C_GEOM.a0 - 2);
   localparam logic [C_HC_W-1:0] C_POP_HI = C_HC_W'(C_GEOM.a0 + 2 * H_ACTIVE - 3);
   localparam logic [C_HC_W-1:0] C_WIN_LO = C_HC_W'(C_GEOM.w0);
   localparam logic [C_HC_W-1:0] C_WIN_HI = C_HC_W'(C_GEOM.w0 + 2 * H_ACTIVE - 1);
   localparam logic [C_HC_W-1:0] C_HS_END = C_HC_W'(2 * H_SYNC);
   localparam logic [C_VC_W-1:0] C_VT_M1  = C_VC_W'(C_VT - 1);
   localparam logic [C_VC_W-1:0] C_VA_LO  = C_VC_W'(V_SYNC + V_BP);
   localparam logic [C_VC_W-1:0] C_VA_HI  = C_VC_W'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [C_VC_W-1:0] C_VS_END = C_VC_W'(V_SYNC);

   logic [C_HC_W-1:0] hc_q, hc_d;
   logic [C_VC_W-1:0] vc_q, vc_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              lcd_hs_q, lcd_hs_d;
   logic              lcd_vs_q, lcd_vs_d;
   logic              pclk_q, pclk_d;
   logic              line_act;

   // Every decode is taken from the next count so the registered flags
   // change on the same edge as hc/vc.
   always_comb begin
      hc_d = hc_q + C_HC_W'(1);
      vc_d = vc_q;
      if (hc_q == C_HT_M1) begin
         hc_d = '0;
         vc_d = (vc_q == C_VT_M1) ? '0 : vc_q + C_VC_W'(1);
      end
      line_act     = (vc_d >= C_VA_LO) && (vc_d <= C_VA_HI);
      pop_due_next = line_act && (hc_d >= C_POP_LO) && (hc_d <= C_POP_HI);
      de_next      = line_act && (hc_d >= C_A0) && (hc_d <= C_DE_HI);
      hsync_d      = !(line_act && (hc_d >= C_WIN_LO) && (hc_d <= C_WIN_HI));
      vsync_d      = !line_act;
      lcd_hs_d     = (hc_d >= C_HS_END);
      lcd_vs_d     = (vc_d >= C_VS_END);
      pclk_d       = hc_d[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q     <= '0;
         vc_q     <= '0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         lcd_hs_q <= 1'b0;
         lcd_vs_q <= 1'b0;
         pclk_q   <= 1'b0;
      end else begin
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         lcd_hs_q <= lcd_hs_d;
         lcd_vs_q <= lcd_vs_d;
         pclk_q   <= pclk_d;
      end
   end

   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign lcd_hs   = lcd_hs_q;
   assign lcd_vs   = lcd_vs_q;
   assign lcd_pclk = pclk_q;

endmodule

`default_nettype wire

// File: rtl/lcd_scan_reader.sv
// ---------------------------------------------------------------------------
// lcd_scan_reader : line-FIFO consumer driving a parallel RGB565 panel
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_scan_reader
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = C_H_ACTIVE,
   parameter int unsigned H_SYNC   = C_H_SYNC,
   parameter int unsigned H_BP     = C_H_BP,
   parameter int unsigned H_FP     = C_H_FP,
   parameter int unsigned V_ACTIVE = C_V_ACTIVE,
   parameter int unsigned V_SYNC   = C_V_SYNC,
   parameter int unsigned V_BP     = C_V_BP,
   parameter int unsigned V_FP     = C_V_FP,
   parameter int unsigned PREFETCH = C_PREFETCH
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        FIFORd,
   input  logic [7:0]  FIFOData,
   input  logic        FIFOEmpty,
   input  logic        ClrUnderrun,
   output logic        Underrun,
   output logic        LCD_PCLK,
   output logic        LCD_HS,
   output logic        LCD_VS,
   output logic        LCD_DE,
   output logic [15:0] LCD_RGB
);

   logic        pop_due_next;
   logic        de_next;
   logic        due_q, due_d;
   logic        fifo_rd_q, fifo_rd_d;
   logic        underrun_q, underrun_d;
   logic        de_q, de_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] rgb_q, rgb_d;
   logic [7:0]  pop_byte;

   lcd_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .H_FP     (H_FP),
      .V_ACTIVE (V_ACTIVE),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .V_FP     (V_FP),
      .PREFETCH (PREFETCH)
   ) u_timing (
      .clk          (CLK),
      .rst_n        (nRST),
      .hsync        (HSYNC),
      .vsync        (VSYNC),
      .lcd_hs       (LCD_HS),
      .lcd_vs       (LCD_VS),
      .lcd_pclk     (LCD_PCLK),
      .pop_due_next (pop_due_next),
      .de_next      (de_next)
   );

   // The pop window starts on an even hc, so LCD_PCLK (hc odd) marks the
   // low-byte slot of each pixel.
   always_comb begin
      due_d      = pop_due_next;
      fifo_rd_d  = pop_due_next & ~FIFOEmpty;
      underrun_d = (pop_due_next & FIFOEmpty) | (underrun_q & ~ClrUnderrun);
      de_d       = de_next;
      pop_byte   = fifo_rd_q ? FIFOData : 8'h00;
      hi_d       = hi_q;
      rgb_d      = rgb_q;
      if (due_q && !LCD_PCLK) begin
         hi_d = pop_byte;
      end
      if (due_q && LCD_PCLK) begin
         rgb_d = {hi_q, pop_byte};
      end
      if (!de_next) begin
         rgb_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         due_q      <= 1'b0;
         fifo_rd_q  <= 1'b0;
         underrun_q <= 1'b0;
         de_q       <= 1'b0;
         hi_q       <= '0;
         rgb_q      <= '0;
      end else begin
         due_q      <= due_d;
         fifo_rd_q  <= fifo_rd_d;
         underrun_q <= underrun_d;
         de_q       <= de_d;
         hi_q       <= hi_d;
         rgb_q      <= rgb_d;
      end
   end

   assign FIFORd   = fifo_rd_q;
   assign Underrun = underrun_q;
   assign LCD_DE   = de_q;
   assign LCD_RGB  = rgb_q;

endmodule

`default_nettype wire
